result_mem_writer: RTL and testbench
====================================

RESULT_MEM_WRITER -- requirements
Module: result_mem_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 640: pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480: lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19: frame memory address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT).
REQ-004 SHALL have parameter DATA_W, default 8: grayscale pixel width.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to capture a frame.
REQ-008 SHALL have port abort  input  1  cancel the frame in progress.
REQ-009 SHALL have port pix_valid  input  1  upstream pixel present.
REQ-010 SHALL have port pix_data  input  DATA_W  pixel value.
REQ-011 SHALL have port pix_last  input  1  upstream end-of-frame marker.
REQ-012 SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-013 SHALL have port mem_we  output  1  frame memory write enable.
REQ-014 SHALL have port mem_addr  output  ADDR_W  frame memory write address.
REQ-015 SHALL have port mem_wdata  output  DATA_W  frame memory write data.
REQ-016 SHALL have port busy  output  1  frame capture in progress.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse when the frame is fully written.
REQ-018 SHALL have port err_sync  output  1  sticky error: pix_last disagreed with pixel count.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-020 IDLE: pix_ready=0; start=1 -> WRITE, address counter, column and row counters cleared to 0, err_sync cleared.
REQ-021 WRITE: pix_ready=1; a handshake is pix_valid & pix_ready in the same cycle.
REQ-022 Each handshake SHALL produce, on the next cycle, mem_we=1, mem_addr=current address, mem_wdata=pix_data (one-cycle registered latency); mem_we=0 otherwise.
REQ-023 Address SHALL increment by 1 per handshake; the column counter wraps WIDTH-1 -> 0 and increments the row counter.
REQ-024 The handshake at address WIDTH*HEIGHT-1 SHALL move WRITE -> DONE; no further pixel is accepted.
REQ-025 DONE SHALL last exactly one cycle with frame_done=1, then return to IDLE.
REQ-026 err_sync SHALL set when pix_last=1 on a non-final handshake, or pix_last=0 on the final handshake; the frame continues by count regardless.
REQ-027 pix_valid=0 in WRITE SHALL stall without advancing the address; no timeout.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in WRITE SHALL return to IDLE next cycle with no frame_done; the pixel handshaked in the abort cycle is discarded (no write issued).
REQ-030 abort and start in the same IDLE cycle: abort wins, stay IDLE.
REQ-031 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-032 Address arithmetic SHALL be unsigned ADDR_W bits; the frame-size compare constant SHALL be computed at elaboration.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, pix_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, err_sync=0, all counters 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; no pending write SHALL be issued after release.

Structure
REQ-035 The FSM state enum, default WIDTH/HEIGHT/DATA_W and the derived FRAME_PIXELS constant SHALL live in a shared package vga_pkg, also used by the frame-memory reader.
REQ-036 The column/row/address counter SHALL be one sub-module, frame_addr_counter (inc, clr inputs; addr, col, row, last outputs).

Verification (bench uses WIDTH=4, HEIGHT=3)
REQ-037 Reset, start, 12 back-to-back pixels 0x00..0x0B with pix_last on the 12th -> writes addr 0..11 with data 0x00..0x0B, frame_done pulse one cycle after the last write, err_sync=0.
REQ-038 Random pix_valid gaps (e.g. valid 0 for 3 cycles after pixel 5) -> same 12 writes in order, no duplicate or skipped address.
REQ-039 pix_last asserted on pixel 6 -> err_sync=1 sticky, 12 writes still complete, frame_done still pulses.
REQ-040 abort during handshake of pixel 7 -> writes only addr 0..6, no frame_done; next start rewrites from addr 0.
REQ-041 start pulsed during WRITE at pixel 3 -> ignored, address sequence unchanged.
REQ-042 rst_n low at pixel 8 -> all outputs 0 asynchronously, no write after release, block in IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer blocks (writer and reader).
//   - default frame geometry and pixel width
//   - FRAME_PIXELS: pixels per frame at the default geometry
//   - wr_state_t: frame writer FSM states
//   - frame_pixels(): frame size for an arbitrary geometry, evaluated at elaboration
//   - cnt_width(): bit width of a counter that must hold 0..n-1
package vga_pkg;

    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;
    localparam int DEF_DATA_W   = 8;
    localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

    // A single-value counter still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Linear address plus column/row position inside a WIDTH x HEIGHT frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance one pixel
//   clr        : restart at pixel 0 (wins over inc)
//   addr       : linear pixel address, row * WIDTH + col
//   col, row   : position of the pixel at addr
//   last       : addr is the final pixel of the frame
module frame_addr_counter
    import vga_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = 19,
    localparam int COL_W = cnt_width(WIDTH),
    localparam int ROW_W = cnt_width(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(frame_pixels(WIDTH, HEIGHT) - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (clr) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_LAST) begin
                col <= '0;
                // Row wraps too so the position is back at (0,0) after the final pixel.
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (addr == ADDR_LAST);

endmodule

// File: rtl/result_mem_writer.sv
// Captures one frame of a pixel stream into a linear frame memory.
// After start, each accepted pixel is written one cycle later at the next
// address; the frame ends by pixel count, and pix_last is only cross-checked.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : one-cycle request to capture a frame (ignored while busy)
//   abort                  : cancel the frame in progress
//   pix_valid/data/last    : upstream pixel stream, pix_last marks end of frame
//   pix_ready              : pixel accepted this cycle when pix_valid is also high
//   mem_we/addr/wdata      : frame memory write port
//   busy                   : capture in progress
//   frame_done             : one-cycle pulse once the final pixel has been written
//   err_sync               : sticky, pix_last disagreed with the pixel count
module result_mem_writer
    import vga_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = 19,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err_sync
);

    localparam int COL_W = cnt_width(WIDTH);
    localparam int ROW_W = cnt_width(HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    wr_state_t         state_q;
    wr_state_t         state_d;
    logic              start_ok;
    logic              hs;
    logic              accept;
    logic [ADDR_W-1:0] cnt_addr;
    logic [COL_W-1:0]  cnt_col;
    logic [ROW_W-1:0]  cnt_row;
    logic              cnt_last;
    logic              exp_last;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic              err_q;
    logic              done_q;

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        start_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort in the same cycle as start keeps the block idle
                if (start && !abort) begin
                    state_d  = WRITE;
                    start_ok = 1'b1;
                end
            end
            WRITE: begin
                pix_ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (pix_valid && cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pixel handshaked in the abort cycle is dropped, not written.
    assign hs     = pix_valid & pix_ready;
    assign accept = hs & ~abort;

    frame_addr_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clr   (start_ok),
        .addr  (cnt_addr),
        .col   (cnt_col),
        .row   (cnt_row),
        .last  (cnt_last)
    );

    // pix_last is expected exactly on the bottom-right pixel.
    assign exp_last = (cnt_col == COL_LAST) && (cnt_row == ROW_LAST);

    // ---- stage p1: registered memory write ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                addr_p1 <= cnt_addr;
                data_p1 <= pix_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (accept && (pix_last != exp_last)) begin
                err_q <= 1'b1;
            end
            // Pulse lands the cycle after the final write is presented to memory.
            done_q <= (state_q == DONE);
        end
    end

    assign mem_we     = vld_p1;
    assign mem_addr   = addr_p1;
    assign mem_wdata  = data_p1;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign err_sync   = err_q;

endmodule

// File: tb/tb_result_mem_writer.sv
module tb_result_mem_writer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          pix_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          frame_done;
    logic          err_sync;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  done_q[$];

    result_mem_writer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .err_sync   (err_sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write and frame_done pulse on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) obs_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
            if (frame_done) done_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one pixel and hold it until it is handshaked (bounded wait).
    task automatic send_pixel(input int idx, input bit last, input bit ab, input bit st, input bit wr);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = DW'(idx);
        pix_last  = last;
        abort     = ab;
        start     = st;
        while (!pix_ready && n < 20) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout pixel=%0d pix_ready=%b required=1", idx, pix_ready);
        end else begin
            if (wr) exp_q.push_back('{idx, idx & 8'hFF, 0});
            tick();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_frame(input int gap_after, input int gap_len, input bit rnd, input int start_at);
        for (int i = 0; i < NPIX; i++) begin
            send_pixel(i, i == NPIX - 1, 1'b0, i == start_at, 1'b1);
            if (i == gap_after) repeat (gap_len) tick();
            else if (rnd) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%0d exp=0", mem_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL reset_err_sync got=%b exp=0", err_sync); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b pix_ready=%b exp=0/0", busy, pix_ready); end
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        int last_cyc;
        clear_queues();
        last_cyc = -100;
        pulse_start();
        checks++; if (busy !== 1'b1 || pix_ready !== 1'b1) begin failures++; $display("FAIL b2b_start busy=%b pix_ready=%b exp=1/1", busy, pix_ready); end
        send_frame(-1, 0, 1'b0, -1);
        repeat (4) tick();
        checks++; if (obs_q.size() != NPIX) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL b2b_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                last_cyc = o.cyc;
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL b2b_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != last_cyc + 1) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", done_q[0], last_cyc + 1); end
        end
        checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL b2b_err_sync got=%b exp=0", err_sync); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_gaps();
        wr_t e, o;
        clear_queues();
        pulse_start();
        send_frame(5, 3, 1'b1, -1);
        repeat (4) tick();
        checks++; if (obs_q.size() != NPIX) begin failures++; $display("FAIL gaps_count got=%0d exp=%0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL gaps_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL gaps_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL gaps_done_count got=%0d exp=1", done_q.size()); end
        checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL gaps_err_sync got=%b exp=0", err_sync); end
    endtask

    task automatic test_last_err();
        wr_t e, o;
        clear_queues();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            send_pixel(i, (i == 6) || (i == NPIX - 1), 1'b0, 1'b0, 1'b1);
            if (i == 5) begin
                checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", err_sync); end
            end
            if (i == 6) begin
                checks++; if (err_sync !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_sync); end
            end
        end
        repeat (4) tick();
        checks++; if (err_sync !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_sync); end
        checks++; if (obs_q.size() != NPIX) begin failures++; $display("FAIL err_count got=%0d exp=%0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL err_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL err_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL err_done_count got=%0d exp=1", done_q.size()); end
        // A fresh start clears the sticky error.
        pulse_start();
        checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got=%b exp=0", err_sync); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        wr_t e, o;
        clear_queues();
        pulse_start();
        for (int i = 0; i < 7; i++) send_pixel(i, 1'b0, 1'b0, 1'b0, 1'b1);
        send_pixel(7, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        repeat (4) tick();
        checks++; if (obs_q.size() != 7) begin failures++; $display("FAIL abort_count got=%0d exp=7", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL abort_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL abort_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_q.size()); end
    endtask

    task automatic test_abort_start_idle();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL abort_wins busy=%b pix_ready=%b exp=0/0", busy, pix_ready); end
    endtask

    task automatic test_start_ignored();
        wr_t e, o;
        clear_queues();
        pulse_start();
        send_frame(-1, 0, 1'b0, 3);
        repeat (4) tick();
        checks++; if (obs_q.size() != NPIX) begin failures++; $display("FAIL busy_start_count got=%0d exp=%0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL busy_start_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL busy_start_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL busy_start_done got=%0d exp=1", done_q.size()); end
    endtask

    task automatic test_reset_mid();
        wr_t e, o;
        clear_queues();
        pulse_start();
        for (int i = 0; i < 8; i++) send_pixel(i, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_valid = 1'b1;
        pix_data  = 8'h08;
        #5;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++; $display("FAIL midrst_mem got=%b/%0d/%0h exp=0/0/0", mem_we, mem_addr, mem_wdata);
        end
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0 || frame_done !== 1'b0 || err_sync !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got=%b%b%b%b exp=0000", busy, pix_ready, frame_done, err_sync);
        end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        pix_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle busy=%b pix_ready=%b exp=0/0", busy, pix_ready); end
        checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL midrst_count got=%0d exp=8", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL midrst_write missing exp_addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data) begin
                    failures++; $display("FAIL midrst_write got=%0d/%0h exp=%0d/%0h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++; if (done_q.size() != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_last_err();
        test_abort();
        test_back_to_back();
        test_abort_start_idle();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
